// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared types and constants for the bit-serial two's-complement to
// sign-magnitude decoder.
package twos_to_signmag_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEFAULT = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/twos_to_signmag_serial_if.sv
// Start/ready/done handshake and result bus of the serial decoder.
interface twos_to_signmag_serial_if
  import twos_to_signmag_serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic             ready;
  logic             done;
  logic             sign;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] smout;
  logic             ovf;

  modport master (
    output start, a,
    input  ready, done, sign, mag, smout, ovf
  );

  modport slave (
    input  start, a,
    output ready, done, sign, mag, smout, ovf
  );
endinterface

// File: rtl/twos_to_signmag_serial_serial_negate_cell.sv
// One-bit serial negation step: copy bits up to and including the first 1,
// invert every later bit when sign is set.
module serial_negate_cell (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic sign,
  input  logic b,
  output logic out
);
  logic seen_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_one <= 1'b0;
    end else if (clear) begin
      seen_one <= 1'b0;
    end else if (en) begin
      seen_one <= seen_one | b;
    end
  end

  assign out = b ^ (sign & seen_one);
endmodule

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial 2's-complement to sign-magnitude decoder, LSB first, one bit
// per clock, with a start/ready/done handshake.
module twos_to_signmag_serial
  import twos_to_signmag_serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic                       clk,
  input logic                       rst,
  twos_to_signmag_serial_if.slave   bus
);
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] src, acc, mag, smout;
  logic [CW-1:0]    cnt;
  logic             flush, sign, ovf, done;
  logic             clear, en, out_bit, last;

  serial_negate_cell u_cell (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (en),
    .sign  (sign),
    .b     (src[0]),
    .out   (out_bit)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    clear    = 1'b0;
    en       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = SHIFT;
          clear    = 1'b1;
        end
      end
      SHIFT: begin
        // The final bit lands in acc one edge before DONE, so the result
        // registers see the complete word when they load on DONE entry.
        if (flush) state_nx = DONE;
        else       en       = 1'b1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      src   <= '0;
      acc   <= '0;
      cnt   <= '0;
      flush <= 1'b0;
      sign  <= 1'b0;
      mag   <= '0;
      smout <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state_nx == DONE);
      if (clear) begin
        src   <= bus.a;
        sign  <= bus.a[WIDTH-1];
        cnt   <= '0;
        flush <= 1'b0;
      end
      if (en) begin
        acc <= {out_bit, acc[WIDTH-1:1]};
        src <= src >> 1;
        if (last) flush <= 1'b1;
        else      cnt   <= cnt + CW'(1);
      end
      if (state == SHIFT && flush) begin
        mag   <= acc;
        smout <= {sign, acc[WIDTH-2:0]};
        ovf   <= sign & acc[WIDTH-1] & ~|acc[WIDTH-2:0];
      end
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = done;
  assign bus.sign  = sign;
  assign bus.mag   = mag;
  assign bus.smout = smout;
  assign bus.ovf   = ovf;
endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Scoreboard bench for twos_to_signmag_serial: directed operands with
// hand-computed results, done-cycle timing and reset behaviour.
module tb_twos_to_signmag_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twos_to_signmag_serial_if #(.WIDTH(32)) bus ();

  twos_to_signmag_serial #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        s;
    logic [31:0] m;
    logic [31:0] sm;
    logic        o;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned ndone    = 0;
  int unsigned cyc      = 0;
  int unsigned pushed   = 0;
  logic        pend_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops an expectation on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (pend_ready) begin
        chk("ready_after_done", {31'd0, bus.ready}, 32'd1);
        pend_ready = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc,               e.cyc);
          chk("sign",       {31'd0, bus.sign}, {31'd0, e.s});
          chk("mag",        bus.mag,           e.m);
          chk("smout",      bus.smout,         e.sm);
          chk("ovf",        {31'd0, bus.ovf},  {31'd0, e.o});
          chk("ready_in_done", {31'd0, bus.ready}, 32'd0);
          pend_ready = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready) return;
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int unsigned n);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (ndone >= n) return;
    end
    chk("done_timeout", ndone, n);
  endtask

  // Issues one operand; leaves start low and a scrambled after capture.
  task automatic issue(input logic [31:0] val, input logic s, input logic [31:0] m,
                       input logic [31:0] sm, input logic o, output int unsigned cap);
    wait_ready();
    bus.start = 1'b1;
    bus.a     = val;
    @(posedge clk);
    #1;
    cap = cyc;
    q.push_back('{s: s, m: m, sm: sm, o: o, cyc: cap + 33});
    pushed++;
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    chk({tag, "_done"},  {31'd0, bus.done},  32'd0);
    chk({tag, "_sign"},  {31'd0, bus.sign},  32'd0);
    chk({tag, "_mag"},   bus.mag,            32'd0);
    chk({tag, "_smout"}, bus.smout,          32'd0);
    chk({tag, "_ovf"},   {31'd0, bus.ovf},   32'd0);
  endtask

  initial begin
    int unsigned cap, nd;
    bus.start = 1'b0;
    bus.a     = '0;

    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    issue(32'h0000_0005, 1'b0, 32'h0000_0005, 32'h0000_0005, 1'b0, cap);
    wait_done(1);
    issue(32'hFFFF_FFFB, 1'b1, 32'h0000_0005, 32'h8000_0005, 1'b0, cap);
    wait_done(2);
    issue(32'h8000_0000, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, cap);
    wait_done(3);
    issue(32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, cap);
    wait_done(4);

    // Starts while busy must be ignored and not queued.
    issue(32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 32'h8000_0001, 1'b0, cap);
    repeat (5) @(negedge clk);
    chk("busy_ready_5", {31'd0, bus.ready}, 32'd0);
    bus.start = 1'b1; bus.a = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("busy_ready_20", {31'd0, bus.ready}, 32'd0);
    bus.start = 1'b1; bus.a = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5);
    repeat (40) @(negedge clk);
    chk("hold_mag",   bus.mag,   32'h0000_0001);
    chk("hold_smout", bus.smout, 32'h8000_0001);
    chk("hold_ndone", ndone,     32'd5);

    // Reset in the middle of a conversion discards it.
    issue(32'h8000_0001, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, cap);
    repeat (10) @(negedge clk);
    nd = ndone;
    #2 rst = 1'b1;
    #1;
    check_cleared("midrst");
    void'(q.pop_back());
    pushed--;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", ndone, nd);
    issue(32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, cap);
    wait_done(6);

    // Back-to-back with start held high: done pulses 35 cycles apart.
    wait_ready();
    bus.start = 1'b1;
    bus.a     = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    cap = cyc;
    q.push_back('{s: 1'b1, m: 32'h0000_0001, sm: 32'h8000_0001, o: 1'b0, cyc: cap + 33});
    q.push_back('{s: 1'b0, m: 32'h0000_0001, sm: 32'h0000_0001, o: 1'b0, cyc: cap + 35 + 33});
    pushed += 2;
    bus.a = 32'h0000_0001;
    wait_ready();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(8);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    chk("done_count",  ndone,    pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
